// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, multiplier FSM states
// and bit positions of the registered flag vector.
package alu_seq_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_MUL  = 4'b1100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } mul_state_t;

  // zero is not stored; it is decoded from the registered result
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ILL   = 2;
  typedef logic [2:0] flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one bit of b per cycle, WIDTH iterations,
// holds its final product with done=1 until the owner acknowledges it.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ack,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output mul_state_t       state
);

  localparam int CW = $clog2(WIDTH);

  mul_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, step;

  // The last iteration is folded into the combinational product, so with
  // the counter at zero the registers freeze and the product stays valid.
  assign step    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = (state_q == S_MUL) && (cnt_q == '0);
  assign product = step;
  assign state   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MUL;
      S_MUL:   if (done && ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        cnt_q    <= CW'(WIDTH - 1);
        acc_q    <= '0;
        mcand_q  <= a;
        mplier_q <= b;
      end else if (state_q == S_MUL && cnt_q != '0) begin
        cnt_q    <= cnt_q - CW'(1);
        acc_q    <= step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; single-cycle ops load the
// output register directly, MUL goes through the iterative multiplier.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             busy
);

  mul_state_t       mul_state;
  logic             mul_done, mul_ack, start_mul, accept, load_alu, load_mul;
  logic [WIDTH-1:0] mul_product;
  flags_t           flags_q;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;

  // Handshake: a transfer happens on an edge where valid & ready are both 1.
  // in_ready never depends on in_valid; out_valid/result/flags stay frozen
  // while out_valid & !out_ready, and a drain may coincide with a new load.
  assign busy      = (mul_state == S_MUL);
  assign in_ready  = !busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (aluop == ALU_MUL);
  assign load_alu  = accept && (aluop != ALU_MUL);
  assign mul_ack   = !out_valid || out_ready;
  assign load_mul  = mul_done && mul_ack;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (start_mul),
    .ack     (mul_ack),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product),
    .state   (mul_state)
  );

  // SUB is a + ~b + 1, so bit WIDTH is carry for ADD and not-borrow for SUB
  assign is_sub = (aluop == ALU_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign shamt  = b[SHW-1:0];

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (aluop)
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_NOR:  alu_res = ~(a | b);
      ALU_ADD, ALU_SUB: begin
        alu_res               = sum[WIDTH-1:0];
        alu_flags[FLAG_CARRY] = sum[WIDTH];
        alu_flags[FLAG_OVF]   = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  alu_res = a << shamt;
      ALU_SRL:  alu_res = a >> shamt;
      ALU_SRA:  alu_res = $signed(a) >>> shamt;
      ALU_MUL:  alu_res = '0;
      default:  alu_flags[FLAG_ILL] = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      flags_q   <= alu_flags;
    end else if (load_mul) begin
      out_valid <= 1'b1;
      result    <= mul_product;
      flags_q   <= '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign zero     = (result == '0);
  assign carry    = flags_q[FLAG_CARRY];
  assign overflow = flags_q[FLAG_OVF];
  assign illegal  = flags_q[FLAG_ILL];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=32: directed vector table, handshake/stall and
// reset-abort sequences, and random traffic scored against an arithmetic model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic         zero, carry, overflow, illegal, busy;
  logic [3:0]   aluop;
  logic [W-1:0] a, b, result;

  int checks = 0;
  int errors = 0;

  // expected entries: {result, zero, carry, overflow, illegal}
  logic [W+3:0] exp_q[$];
  logic [W+3:0] sb_e;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   fl;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .SHW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal),
    .busy      (busy)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference built from plain integer arithmetic on 64-bit values.
  function automatic logic [W+3:0] model(logic [3:0] op, logic [W-1:0] x, logic [W-1:0] y);
    longint unsigned ux = 64'(x);
    longint unsigned uy = 64'(y);
    longint unsigned uw;
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint          sw;
    int              sh = int'(y[4:0]);
    logic [W-1:0]    r  = '0;
    logic            c  = 1'b0;
    logic            v  = 1'b0;
    logic            il = 1'b0;
    case (op)
      ALU_AND:  r = x & y;
      ALU_OR:   r = x | y;
      ALU_XOR:  r = x ^ y;
      ALU_NOR:  r = ~(x | y);
      ALU_ADD: begin
        uw = ux + uy;
        r  = uw[W-1:0];
        c  = uw[W];
        sw = sx + sy;
        v  = (sw != longint'($signed(sw[W-1:0])));
      end
      ALU_SUB: begin
        r  = x - y;
        c  = (ux >= uy);
        sw = sx - sy;
        v  = (sw != longint'($signed(sw[W-1:0])));
      end
      ALU_SLT:  r = W'(sx < sy);
      ALU_SLTU: r = W'(ux < uy);
      ALU_SLL:  r = x << sh;
      ALU_SRL:  r = x >> sh;
      ALU_SRA:  r = $signed(x) >>> sh;
      ALU_MUL: begin
        uw = ux * uy;
        r  = uw[W-1:0];
      end
      default:  il = 1'b1;
    endcase
    return {r, (r == '0), c, v, il};
  endfunction

  // scoreboard: pop on each delivered result, push on each accepted op
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got result %0h with no expected entry", result);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_result", 64'(result), 64'(sb_e[W+3:4]));
          check("sb_flags", 64'({zero, carry, overflow, illegal}), 64'(sb_e[3:0]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(aluop, a, b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W+3:0] got, output int lat);
    int waitc = 0;
    int bad   = 0;
    aluop    = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    while (!in_ready && waitc < 200) begin
      tick();
      waitc++;
    end
    check("accept_wait_bound", 64'(waitc < 200), 64'(1));
    tick();
    in_valid = 1'b0;
    aluop    = 4'($urandom);
    a        = $urandom;
    b        = $urandom;
    lat      = 0;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) bad++;
      tick();
      lat++;
    end
    got = {result, zero, carry, overflow, illegal};
    if (op == ALU_MUL) check("mul_busy_no_ready", 64'(bad), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+3:0] got, last;
    int           lat, n;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    aluop     = '0;
    a         = '0;
    b         = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_flags", 64'({zero, carry, overflow, illegal}), 64'(4'b1000));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));

    // fl = {zero, carry, overflow, illegal}
    vecs = '{
      '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100},
      '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0110},
      '{ALU_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 4'b0000},
      '{ALU_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 4'b1000},
      '{ALU_MUL,  32'h00010003, 32'h00000005, 32'h0005000F, 4'b0000},
      '{4'b0101,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1001},
      '{ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 4'b0000},
      '{ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000},
      '{ALU_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000},
      '{ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 4'b0000},
      '{ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0000},
      '{ALU_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 4'b0000},
      '{ALU_SRL,  32'h80000000, 32'h00000024, 32'h08000000, 4'b0000},
      '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 4'b1100},
      '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0010},
      '{4'b1111,  32'h12345678, 32'h00000001, 32'h00000000, 4'b1001},
      '{ALU_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000},
      '{ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0000}
    };

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, got, lat);
      check($sformatf("vec%0d_result", i), 64'(got[W+3:4]), 64'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 64'(got[3:0]), 64'(vecs[i].fl));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'((vecs[i].op == ALU_MUL) ? W : 0));
    end

    // back-to-back ADDs, then a 5-cycle consumer stall, then release
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      aluop    = ALU_ADD;
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'b1;
      #1;
      check("b2b_in_ready", 64'(in_ready), 64'(1));
      last = model(ALU_ADD, a, b);
      tick();
      check("b2b_out_valid", 64'(out_valid), 64'(1));
      check("b2b_result", 64'({result, zero, carry, overflow, illegal}), 64'(last));
    end
    out_ready = 1'b0;
    a         = $urandom;
    b         = $urandom;
    #1;
    check("stall_in_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_hold", 64'({result, zero, carry, overflow, illegal}), 64'(last));
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(in_ready), 64'(1));
    last = model(ALU_ADD, a, b);
    tick();
    in_valid = 1'b0;
    check("release_out_valid", 64'(out_valid), 64'(1));
    check("release_result", 64'({result, zero, carry, overflow, illegal}), 64'(last));

    // MUL finishing while the consumer is not ready: result must wait
    a        = $urandom;
    b        = $urandom;
    last     = model(ALU_MUL, a, b);
    aluop    = ALU_MUL;
    in_valid = 1'b1;
    n        = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    lat       = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("mul_stall_latency", 64'(lat), 64'(W));
    repeat (3) tick();
    check("mul_stall_valid", 64'(out_valid), 64'(1));
    check("mul_stall_result", 64'({result, zero, carry, overflow, illegal}), 64'(last));
    out_ready = 1'b1;
    tick();

    // reset during MUL aborts with no partial result
    aluop    = ALU_MUL;
    a        = 32'h00010003;
    b        = 32'h00000005;
    in_valid = 1'b1;
    n        = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_zero", 64'(zero), 64'(1));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) n++;
      tick();
    end
    check("abort_no_result", 64'(n), 64'(0));
    run_op(ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, got, lat);
    check("abort_then_and", 64'(got[W+3:4]), 64'(32'h00F000F0));

    // random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      aluop     = 4'($urandom_range(0, 15));
      a         = $urandom;
      b         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
